// File: rtl/lsrt_pkg.sv
// Shared definitions for the lsrt serial responder: state encodings and frame sizing.
package lsrt_pkg;

  typedef enum logic [1:0] {
    st_idle  = 2'b00,
    st_clear = 2'b01,
    st_shift = 2'b10,
    st_done  = 2'b11
  } lsrt_st_e;

  function automatic int unsigned frame_bits(input int unsigned dmsb);
    return dmsb + 1;
  endfunction

endpackage

// File: rtl/handshake_xor.sv
// Toggle-to-pulse converter: one-cycle pulse whenever d differs from its last sampled value.
module handshake_xor (
  input  logic clk,
  input  logic rstn,
  input  logic setn,
  input  logic d,
  output logic pulse_c
);

  logic d_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)     d_q <= 1'b0;
    else if (setn) d_q <= d;
  end

  assign pulse_c = d ^ d_q;

endmodule

// File: rtl/lsrt_sync2.sv
// Two-flop synchroniser for a single asynchronous input, frozen by setn.
module lsrt_sync2 (
  input  logic clk,
  input  logic rstn,
  input  logic setn,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else if (setn) begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/lsrt_slave.sv
// lsrt link responder: full-duplex shifter clocked by master ucki toggles, with
// one-word transmit/receive buffering and underrun/overrun/timeout flags.
module lsrt_slave
  import lsrt_pkg::*;
#(
  parameter int unsigned DMSB = 9,
  parameter int unsigned BMSB = 3,
  parameter int unsigned TMSB = 11
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              setn,
  input  logic              ucki,
  input  logic              sdi,
  output logic              sdo,
  input  logic              load,
  input  logic signed [DMSB:0] wdata,
  output logic              tx_empty,
  input  logic              rd_ack,
  output logic signed [DMSB:0] rdata,
  output logic              rvalid,
  input  logic              clear,
  input  logic [TMSB:0]     tmo,
  output logic              err,
  output logic              ovr,
  output logic              udr,
  output logic [1:0]        cst,
  output logic              busy
);

  localparam int unsigned DW = frame_bits(DMSB);
  localparam int unsigned BW = BMSB + 1;
  localparam int unsigned TW = TMSB + 1;
  localparam logic [BMSB:0] BTH_START = BW'(DW - 2);

  logic ucki_s, sdi_s;
  logic ucki_x, load_x, rd_ack_x, clear_x;

  lsrt_sync2 u_sync_ucki (.clk(clk), .rstn(rstn), .setn(setn), .d(ucki), .q(ucki_s));
  lsrt_sync2 u_sync_sdi  (.clk(clk), .rstn(rstn), .setn(setn), .d(sdi),  .q(sdi_s));

  handshake_xor u_hx_ucki (.clk(clk), .rstn(rstn), .setn(setn), .d(ucki_s), .pulse_c(ucki_x));
  handshake_xor u_hx_load (.clk(clk), .rstn(rstn), .setn(setn), .d(load),   .pulse_c(load_x));
  handshake_xor u_hx_ack  (.clk(clk), .rstn(rstn), .setn(setn), .d(rd_ack), .pulse_c(rd_ack_x));
  handshake_xor u_hx_clr  (.clk(clk), .rstn(rstn), .setn(setn), .d(clear),  .pulse_c(clear_x));

  lsrt_st_e      st_q, st_nx;
  logic [DMSB:0] rxsr_q, rxsr_nx, txsr_q, txsr_nx, txbuf_q, txbuf_nx;
  logic [DMSB:0] rdata_nx;
  logic          txbuf_vld_q, txbuf_vld_nx, tx_empty_nx, rvalid_nx;
  logic          err_nx, ovr_nx, udr_nx, busy_nx;
  logic [BMSB:0] bth_q, bth_nx;
  logic [TMSB:0] tcnt_q, tcnt_nx;

  assign sdo = txsr_q[0];
  assign cst = st_q;

  // Next-state and datapath update
  always_comb begin
    st_nx        = st_q;
    rxsr_nx      = rxsr_q;
    txsr_nx      = txsr_q;
    txbuf_nx     = txbuf_q;
    txbuf_vld_nx = txbuf_vld_q;
    tx_empty_nx  = tx_empty;
    rdata_nx     = rdata;
    rvalid_nx    = rvalid;
    err_nx       = err;
    ovr_nx       = ovr;
    udr_nx       = udr;
    bth_nx       = bth_q;
    tcnt_nx      = tcnt_q;

    if (rd_ack_x) rvalid_nx = 1'b0;

    case (st_q)
      st_idle, st_clear: begin
        if (load_x) begin
          txsr_nx     = wdata;
          tx_empty_nx = 1'b0;
        end
        if (st_q == st_clear) begin
          err_nx  = 1'b0;
          ovr_nx  = 1'b0;
          udr_nx  = 1'b0;
          rxsr_nx = '0;
          tcnt_nx = '0;
          bth_nx  = '0;
          st_nx   = st_idle;
        end else if (clear_x) begin
          st_nx = st_clear;
        end else if (ucki_x) begin
          rxsr_nx = {sdi_s, rxsr_q[DMSB:1]};
          txsr_nx = {1'b0, txsr_q[DMSB:1]};
          bth_nx  = BTH_START;
          tcnt_nx = '0;
          if (tx_empty) udr_nx = 1'b1;
          st_nx   = st_shift;
        end
      end
      st_shift: begin
        if (load_x) begin
          txbuf_nx     = wdata;
          txbuf_vld_nx = 1'b1;
        end
        if (clear_x) begin
          st_nx = st_clear;
        end else if (ucki_x) begin
          rxsr_nx = {sdi_s, rxsr_q[DMSB:1]};
          txsr_nx = {1'b0, txsr_q[DMSB:1]};
          bth_nx  = bth_q - BW'(1);
          tcnt_nx = '0;
          if (bth_q == '0) st_nx = st_done;
        end else if (tcnt_q == tmo) begin
          err_nx  = 1'b1;
          tcnt_nx = '0;
          st_nx   = st_idle;
        end else begin
          tcnt_nx = tcnt_q + TW'(1);
        end
      end
      default: begin
        rdata_nx  = rxsr_q;
        rvalid_nx = 1'b1;
        if (rvalid && !rd_ack_x) ovr_nx = 1'b1;
        if (txbuf_vld_q) begin
          txsr_nx     = txbuf_q;
          tx_empty_nx = 1'b0;
        end else begin
          txsr_nx     = '0;
          tx_empty_nx = 1'b1;
        end
        // A load landing in this cycle queues behind the word just transferred
        txbuf_vld_nx = load_x;
        if (load_x) txbuf_nx = wdata;
        st_nx = st_idle;
      end
    endcase

    busy_nx = (st_nx != st_idle);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st_q        <= st_idle;
      rxsr_q      <= '0;
      txsr_q      <= '0;
      txbuf_q     <= '0;
      txbuf_vld_q <= 1'b0;
      tx_empty    <= 1'b1;
      rdata       <= '0;
      rvalid      <= 1'b0;
      err         <= 1'b0;
      ovr         <= 1'b0;
      udr         <= 1'b0;
      bth_q       <= '0;
      tcnt_q      <= '0;
      busy        <= 1'b0;
    end else if (setn) begin
      st_q        <= st_nx;
      rxsr_q      <= rxsr_nx;
      txsr_q      <= txsr_nx;
      txbuf_q     <= txbuf_nx;
      txbuf_vld_q <= txbuf_vld_nx;
      tx_empty    <= tx_empty_nx;
      rdata       <= rdata_nx;
      rvalid      <= rvalid_nx;
      err         <= err_nx;
      ovr         <= ovr_nx;
      udr         <= udr_nx;
      bth_q       <= bth_nx;
      tcnt_q      <= tcnt_nx;
      busy        <= busy_nx;
    end
  end

endmodule

// File: tb/tb_lsrt_slave.sv
// Directed bench for lsrt_slave: acts as the master, toggling ucki every 8 clk cycles.
module tb_lsrt_slave;

  logic        clk = 1'b0;
  logic        rstn, setn, ucki, sdi, load, rd_ack, clear;
  logic [9:0]  wdata;
  logic [11:0] tmo;
  logic        sdo, tx_empty, rvalid, err, ovr, udr, busy;
  logic [9:0]  rdata;
  logic [1:0]  cst;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  lsrt_slave dut (
    .clk(clk), .rstn(rstn), .setn(setn), .ucki(ucki), .sdi(sdi), .sdo(sdo),
    .load(load), .wdata(wdata), .tx_empty(tx_empty), .rd_ack(rd_ack),
    .rdata(rdata), .rvalid(rvalid), .clear(clear), .tmo(tmo), .err(err),
    .ovr(ovr), .udr(udr), .cst(cst), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tog(input logic b);
    sdi  = b;
    ucki = ~ucki;
    cyc(8);
  endtask

  task automatic frame(input logic [9:0] rx, input logic [9:0] tx, input bit chk_tx,
                       input string tag);
    for (int i = 0; i < 10; i++) begin
      if (chk_tx) chk($sformatf("%s_sdo%0d", tag, i), 16'(sdo), 16'(tx[i]));
      tog(rx[i]);
    end
  endtask

  task automatic do_load(input logic [9:0] w);
    wdata = w;
    load  = ~load;
    cyc(1);
  endtask

  task automatic do_ack();
    rd_ack = ~rd_ack;
    cyc(1);
  endtask

  task automatic do_clr();
    clear = ~clear;
    cyc(2);
  endtask

  initial begin
    logic [9:0] w;
    rstn = 1'b0; setn = 1'b1; ucki = 1'b0; sdi = 1'b0;
    load = 1'b0; rd_ack = 1'b0; clear = 1'b0; wdata = '0; tmo = 12'd20;
    cyc(3);
    rstn = 1'b1;
    cyc(2);

    // reset state
    chk("rst_sdo", 16'(sdo), 16'h0);
    chk("rst_rdata", 16'(rdata), 16'h0);
    chk("rst_rvalid", 16'(rvalid), 16'h0);
    chk("rst_flags", 16'({err, ovr, udr}), 16'h0);
    chk("rst_cst", 16'(cst), 16'h0);
    chk("rst_tx_empty", 16'(tx_empty), 16'h1);
    chk("rst_busy", 16'(busy), 16'h0);

    // basic frame
    do_load(10'h155);
    chk("basic_tx_empty_ld", 16'(tx_empty), 16'h0);
    frame(10'h2A5, 10'h155, 1'b1, "basic");
    chk("basic_rdata", 16'(rdata), 16'h2A5);
    chk("basic_rvalid", 16'(rvalid), 16'h1);
    chk("basic_tx_empty", 16'(tx_empty), 16'h1);
    chk("basic_udr", 16'(udr), 16'h0);
    chk("basic_ovr", 16'(ovr), 16'h0);
    chk("basic_cst", 16'(cst), 16'h0);
    do_ack();
    chk("basic_ack_rvalid", 16'(rvalid), 16'h0);

    // underrun
    frame(10'h0C3, 10'h000, 1'b1, "udr");
    chk("udr_flag", 16'(udr), 16'h1);
    chk("udr_rdata", 16'(rdata), 16'h0C3);
    chk("udr_ovr", 16'(ovr), 16'h0);
    do_ack();
    do_clr();
    chk("udr_cleared", 16'(udr), 16'h0);

    // overrun
    frame(10'h001, 10'h000, 1'b0, "ovr1");
    chk("ovr_first", 16'(ovr), 16'h0);
    frame(10'h3FF, 10'h000, 1'b0, "ovr2");
    chk("ovr_rdata", 16'(rdata), 16'h3FF);
    chk("ovr_flag", 16'(ovr), 16'h1);
    chk("ovr_rvalid", 16'(rvalid), 16'h1);
    do_ack();
    chk("ovr_ack_rvalid", 16'(rvalid), 16'h0);
    chk("ovr_sticky", 16'(ovr), 16'h1);
    do_clr();
    chk("ovr_cleared", 16'(ovr), 16'h0);

    // timeout after 4 toggles
    w = 10'h3C3;
    for (int i = 0; i < 4; i++) tog(w[i]);
    cyc(2);
    chk("tmo_early_err", 16'(err), 16'h0);
    chk("tmo_early_cst", 16'(cst), 16'h2);
    chk("tmo_early_busy", 16'(busy), 16'h1);
    cyc(25);
    chk("tmo_err", 16'(err), 16'h1);
    chk("tmo_cst", 16'(cst), 16'h0);
    chk("tmo_rdata", 16'(rdata), 16'h3FF);
    chk("tmo_rvalid", 16'(rvalid), 16'h0);
    frame(10'h1E7, 10'h000, 1'b0, "tmo_next");
    chk("tmo_next_rdata", 16'(rdata), 16'h1E7);
    chk("tmo_next_rvalid", 16'(rvalid), 16'h1);
    do_ack();
    do_clr();
    chk("tmo_err_cleared", 16'(err), 16'h0);

    // reset mid-frame
    do_load(10'h0AA);
    w = 10'h155;
    for (int i = 0; i < 5; i++) tog(w[i]);
    rstn = 1'b0; ucki = 1'b0; sdi = 1'b0; load = 1'b0; rd_ack = 1'b0; clear = 1'b0;
    #1;
    chk("mrst_sdo", 16'(sdo), 16'h0);
    chk("mrst_cst", 16'(cst), 16'h0);
    chk("mrst_tx_empty", 16'(tx_empty), 16'h1);
    chk("mrst_rdata", 16'(rdata), 16'h0);
    chk("mrst_busy", 16'(busy), 16'h0);
    cyc(2);
    rstn = 1'b1;
    cyc(2);
    frame(10'h0F0, 10'h000, 1'b1, "mrst_frame");
    chk("mrst_frame_rdata", 16'(rdata), 16'h0F0);
    chk("mrst_frame_rvalid", 16'(rvalid), 16'h1);
    do_ack();
    do_clr();

    // queued load during shift
    do_load(10'h2CC);
    w = 10'h0A5;
    for (int i = 0; i < 10; i++) begin
      logic [9:0] t;
      t = 10'h2CC;
      chk($sformatf("q_old_sdo%0d", i), 16'(sdo), 16'(t[i]));
      if (i == 3) begin
        wdata = 10'h111;
        load  = ~load;
      end
      tog(w[i]);
    end
    chk("q_rdata", 16'(rdata), 16'h0A5);
    chk("q_tx_empty", 16'(tx_empty), 16'h0);
    frame(10'h000, 10'h111, 1'b1, "q_new");
    chk("q_new_tx_empty", 16'(tx_empty), 16'h1);
    chk("q_udr", 16'(udr), 16'h0);
    do_ack();
    do_ack();
    do_clr();

    // freeze mid-frame
    w = 10'h35A;
    for (int i = 0; i < 3; i++) tog(w[i]);
    setn = 1'b0;
    cyc(30);
    chk("frz_cst", 16'(cst), 16'h2);
    chk("frz_bth", 16'(dut.bth_q), 16'h6);
    chk("frz_tcnt", 16'(dut.tcnt_q), 16'h5);
    chk("frz_err", 16'(err), 16'h0);
    setn = 1'b1;
    for (int i = 3; i < 10; i++) tog(w[i]);
    chk("frz_rdata", 16'(rdata), 16'h35A);
    chk("frz_err_end", 16'(err), 16'h0);
    chk("frz_cst_end", 16'(cst), 16'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
